// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers.
// Keeps its own occupancy count so grants never overrun the FIFO.
module fifo_wr_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 4,
   parameter int CAP  = 7,
   parameter int OW   = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NREQ-1:0]      req_valid_i,
   input  logic [NREQ*DW-1:0]   req_data_i,
   output logic [NREQ-1:0]      req_ready_o,
   output logic                 fifo_wr_en_o,
   output logic [DW-1:0]        fifo_wr_data_o,
   input  logic                 fifo_rd_fire_i,
   output logic [OW-1:0]        occ_o,
   output logic [2:0]           grant_id_o,
   output logic                 err_unf_o
);

   localparam int IW = 3;

   logic [IW-1:0]   rr_q, rr_d;
   logic [OW-1:0]   occ_q, occ_d;
   logic [IW-1:0]   grant_id_q;
   logic            wr_en_q;
   logic [DW-1:0]   wr_data_q;
   logic            err_unf_q;

   logic            avail;
   logic            lo_found, hi_found;
   logic [IW-1:0]   lo_idx, hi_idx, g;
   logic [NREQ-1:0] req_ready;
   logic            acc, rd;
   logic [DW-1:0]   sel_data;

   assign avail = (occ_q < OW'(CAP));

   // Lowest valid index at or above rr wins; otherwise wrap to the lowest valid index overall.
   always_comb begin
      lo_found = 1'b0;
      hi_found = 1'b0;
      lo_idx   = '0;
      hi_idx   = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (req_valid_i[j]) begin
            lo_found = 1'b1;
            lo_idx   = IW'(j);
            if (IW'(j) >= rr_q) begin
               hi_found = 1'b1;
               hi_idx   = IW'(j);
            end
         end
      end
      g = hi_found ? hi_idx : lo_idx;
      req_ready = '0;
      if (!rst_i && avail && lo_found) begin
         req_ready = NREQ'(1) << g;
      end
   end

   always_comb begin
      sel_data = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (IW'(j) == g) begin
            sel_data = req_data_i[j*DW +: DW];
         end
      end
   end

   assign acc = |(req_valid_i & req_ready);
   assign rd  = fifo_rd_fire_i && (occ_q != '0);

   always_comb begin
      occ_d = occ_q;
      case ({acc, rd})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
      rr_d = (g == IW'(NREQ - 1)) ? '0 : g + IW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q       <= '0;
         occ_q      <= '0;
         grant_id_q <= '0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
         err_unf_q  <= 1'b0;
      end else begin
         wr_en_q <= acc;
         occ_q   <= occ_d;
         if (acc) begin
            wr_data_q  <= sel_data;
            grant_id_q <= g;
            rr_q       <= rr_d;
         end
         if (fifo_rd_fire_i && (occ_q == '0)) begin
            err_unf_q <= 1'b1;
         end
      end
   end

   assign req_ready_o    = req_ready;
   assign fifo_wr_en_o   = wr_en_q;
   assign fifo_wr_data_o = wr_data_q;
   assign occ_o          = occ_q;
   assign grant_id_o     = grant_id_q;
   assign err_unf_o      = err_unf_q;

endmodule
